ccdl_rx_decoder: RTL and testbench

Receive-side CCDL line decoder: recovers 16-bit words from the Manchester-coded serial input, checks sync, coding and parity, and pushes good words into the CCDL receive FIFO. It sits between the line input (the normal input or the self-test wrap-back, muxed outside) and the RX FIFO inside the CCDL top level, running in the 80 MHz domain. It is the counterpart of the CCDL encoder.

---
 rtl/ccdl_pkg.sv | 19 +
 rtl/ccdl_rx_decoder_if.sv | 21 ++
 rtl/ccdl_line_sync.sv | 32 +++
 rtl/ccdl_rx_decoder.sv | 193 +++++++++++++++++++
 tb/tb_ccdl_rx_decoder.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ccdl_pkg.sv
// Shared CCDL definitions: decoder state encoding, frame geometry and Manchester polarity.
// Used by both the line encoder and the receive decoder.
package ccdl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSyncLo,
    StSyncHi,
    StData,
    StCheck
  } ccdl_state_e;

  localparam int unsigned C_DATA_BITS  = 16;
  localparam int unsigned C_FRAME_BITS = 17;

  // Level of the first half-bit that encodes a logical '1'.
  localparam logic C_MANCH_ONE_FIRST = 1'b1;

endpackage

// File: rtl/ccdl_rx_decoder_if.sv
// Write-side handshake between the CCDL receive decoder and the RX FIFO.
interface ccdl_rx_decoder_if;
  import ccdl_pkg::*;

  logic [C_DATA_BITS-1:0] rx_data;
  logic                   wr_en;
  logic                   fifo_full;

  modport master (
    output rx_data,
    output wr_en,
    input  fifo_full
  );

  modport slave (
    input  rx_data,
    input  wr_en,
    output fifo_full
  );

endinterface

// File: rtl/ccdl_line_sync.sv
// Two-flop synchronizer for the asynchronous CCDL line plus one-cycle rise/fall pulses.
// Flops reset to the idle-high level so a reset never manufactures a falling edge.
module ccdl_line_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line_i,
  output logic s_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic s_q;
  logic s_prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q   <= 1'b1;
      s_q      <= 1'b1;
      s_prev_q <= 1'b1;
    end else begin
      meta_q   <= line_i;
      s_q      <= meta_q;
      s_prev_q <= s_q;
    end
  end

  assign s_o    = s_q;
  assign rise_o = s_q & ~s_prev_q;
  assign fall_o = ~s_q & s_prev_q;

endmodule

// File: rtl/ccdl_rx_decoder.sv
// CCDL receive decoder: qualifies the 1.5+1.5 bit sync, samples 17 Manchester bits,
// checks odd parity and pushes good words into the RX FIFO.
module ccdl_rx_decoder
  import ccdl_pkg::*;
#(
  parameter int unsigned C_OSR = 8,
  parameter int unsigned C_TOL = 2
) (
  input  logic              I_clk_80M,
  input  logic              I_rst,
  input  logic              I_decode_en,
  input  logic              I_clr,
  input  logic              I_COM_CCDL_IN,
  ccdl_rx_decoder_if.master fifo,
  output logic              O_busy,
  output logic [15:0]       O_frame_cnt,
  output logic [7:0]        O_err_cnt,
  output logic              O_parity_err,
  output logic              O_manch_err,
  output logic              O_overflow
);

  localparam int unsigned H   = C_OSR / 2;
  localparam int unsigned PhW = $clog2(3 * C_OSR + C_OSR);

  localparam logic [PhW-1:0] PhOne     = PhW'(1);
  localparam logic [PhW-1:0] PhHalf    = PhW'(H);
  localparam logic [PhW-1:0] PhTwoH    = PhW'(2 * H);
  localparam logic [PhW-1:0] PhSyncEnd = PhW'(3 * H - 1);
  localparam logic [PhW-1:0] PhOsr     = PhW'(C_OSR);
  localparam logic [PhW-1:0] PhBitEnd  = PhW'(C_OSR - 1);
  localparam logic [PhW-1:0] PhFirst   = PhW'(H / 2);
  localparam logic [PhW-1:0] PhSecond  = PhW'(H + H / 2);
  localparam logic [PhW-1:0] PhLoMin   = PhW'(3 * H - C_TOL);
  localparam logic [PhW-1:0] PhLoMax   = PhW'(3 * H + C_TOL);
  localparam logic [4:0]     LastBit   = 5'(C_FRAME_BITS - 1);

  logic s;
  logic rise;
  logic fall;

  ccdl_line_sync u_line_sync (
    .clk_i  (I_clk_80M),
    .rst_i  (I_rst),
    .line_i (I_COM_CCDL_IN),
    .s_o    (s),
    .rise_o (rise),
    .fall_o (fall)
  );

  ccdl_state_e              state_q;
  logic [PhW-1:0]           phase_q;
  logic [4:0]               bit_idx_q;
  logic                     first_q;
  logic [C_FRAME_BITS-2:0]  shift_q;
  logic [C_DATA_BITS-1:0]   rx_data_q;
  logic                     wr_en_q;
  logic [15:0]              frame_cnt_q;
  logic [7:0]               err_cnt_q;
  logic                     parity_err_q;
  logic                     manch_err_q;
  logic                     overflow_q;

  logic                     new_bit;
  logic [C_FRAME_BITS-1:0]  frame_w;
  logic [7:0]               err_cnt_inc;

  assign new_bit     = (first_q == C_MANCH_ONE_FIRST);
  assign frame_w     = {shift_q, new_bit};
  assign err_cnt_inc = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

  // In IDLE and SYNC_LO phase_q is a run length; afterwards it is the time since the
  // mid-sync rising edge (SYNC_HI) or the offset within the current bit (DATA).
  always_ff @(posedge I_clk_80M) begin
    if (I_rst) begin
      state_q      <= StIdle;
      phase_q      <= '0;
      bit_idx_q    <= '0;
      first_q      <= 1'b0;
      shift_q      <= '0;
      rx_data_q    <= '0;
      wr_en_q      <= 1'b0;
      frame_cnt_q  <= '0;
      err_cnt_q    <= '0;
      parity_err_q <= 1'b0;
      manch_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      if (!I_decode_en && state_q != StIdle) begin
        state_q <= StIdle;
        phase_q <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (I_decode_en && fall && phase_q >= PhOsr) begin
              state_q <= StSyncLo;
              phase_q <= PhOne;
            end else if (s) begin
              if (phase_q != PhOsr) phase_q <= phase_q + PhOne;
            end else begin
              phase_q <= '0;
            end
          end
          StSyncLo: begin
            if (rise) begin
              if (phase_q >= PhLoMin && phase_q <= PhLoMax) begin
                state_q <= StSyncHi;
              end else begin
                state_q <= StIdle;
              end
              phase_q <= PhOne;
            end else if (phase_q >= PhLoMax) begin
              state_q <= StIdle;
              phase_q <= '0;
            end else begin
              phase_q <= phase_q + PhOne;
            end
          end
          StSyncHi: begin
            if ((phase_q == PhHalf || phase_q == PhTwoH) && !s) begin
              err_cnt_q <= err_cnt_inc;
              state_q   <= StIdle;
              phase_q   <= '0;
            end else if (phase_q == PhSyncEnd) begin
              state_q   <= StData;
              phase_q   <= '0;
              bit_idx_q <= '0;
            end else begin
              phase_q <= phase_q + PhOne;
            end
          end
          StData: begin
            if (phase_q == PhFirst) first_q <= s;
            if (phase_q == PhSecond && s == first_q) begin
              manch_err_q <= 1'b1;
              err_cnt_q   <= err_cnt_inc;
              state_q     <= StIdle;
              phase_q     <= '0;
            end else if (phase_q == PhSecond && bit_idx_q == LastBit) begin
              // Verdict is taken with the parity bit so the write lands in the CHECK cycle.
              state_q <= StCheck;
              phase_q <= '0;
              if (!(^frame_w)) begin
                parity_err_q <= 1'b1;
                err_cnt_q    <= err_cnt_inc;
              end else if (fifo.fifo_full) begin
                overflow_q <= 1'b1;
              end else begin
                rx_data_q   <= frame_w[C_FRAME_BITS-1:1];
                wr_en_q     <= 1'b1;
                frame_cnt_q <= frame_cnt_q + 16'd1;
              end
            end else begin
              if (phase_q == PhSecond) shift_q <= frame_w[C_FRAME_BITS-2:0];
              if (phase_q == PhBitEnd) begin
                phase_q   <= '0;
                bit_idx_q <= bit_idx_q + 5'd1;
              end else begin
                phase_q <= phase_q + PhOne;
              end
            end
          end
          StCheck: begin
            state_q <= StIdle;
            phase_q <= '0;
          end
          default: begin
            state_q <= StIdle;
            phase_q <= '0;
          end
        endcase
      end
      if (I_clr) begin
        frame_cnt_q  <= '0;
        err_cnt_q    <= '0;
        parity_err_q <= 1'b0;
        manch_err_q  <= 1'b0;
        overflow_q   <= 1'b0;
      end
    end
  end

  assign fifo.rx_data = rx_data_q;
  assign fifo.wr_en   = wr_en_q;
  assign O_busy       = (state_q != StIdle);
  assign O_frame_cnt  = frame_cnt_q;
  assign O_err_cnt    = err_cnt_q;
  assign O_parity_err = parity_err_q;
  assign O_manch_err  = manch_err_q;
  assign O_overflow   = overflow_q;

endmodule

// File: tb/tb_ccdl_rx_decoder.sv
// Directed bench for ccdl_rx_decoder at C_OSR = 8: frames are built as per-clock line
// samples, driven on the falling clock edge, and outputs are observed there as well.
module tb_ccdl_rx_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        decode_en;
  logic        clr;
  logic        line;
  logic        busy;
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;
  logic        parity_err;
  logic        manch_err;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  logic wave[$];

  ccdl_rx_decoder_if fifo_if ();

  ccdl_rx_decoder #(
    .C_OSR (8),
    .C_TOL (2)
  ) dut (
    .I_clk_80M     (clk),
    .I_rst         (rst),
    .I_decode_en   (decode_en),
    .I_clr         (clr),
    .I_COM_CCDL_IN (line),
    .fifo          (fifo_if),
    .O_busy        (busy),
    .O_frame_cnt   (frame_cnt),
    .O_err_cnt     (err_cnt),
    .O_parity_err  (parity_err),
    .O_manch_err   (manch_err),
    .O_overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Appends sync + 17 Manchester bits; bad_bit >= 0 sends that bit with both halves high.
  task automatic add_frame(input logic [15:0] data, input int low_len, input bit bad_parity,
                           input int bad_bit);
    logic [16:0] f;
    logic        b;
    for (int i = 0; i < low_len; i++) wave.push_back(1'b0);
    for (int i = 0; i < 12; i++) wave.push_back(1'b1);
    b = ~(^data);
    if (bad_parity) b = ~b;
    f = {data, b};
    for (int k = 0; k < 17; k++) begin
      b = f[16-k];
      for (int j = 0; j < 8; j++) begin
        if (k == bad_bit) wave.push_back(1'b1);
        else wave.push_back((j < 4) ? b : ~b);
      end
    end
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) wave.push_back(1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      line = 1'b1;
    end
  endtask

  // Drives the queued wave plus a high tail; index i is observed before sample i is driven.
  task automatic play(input int tail, input int rst_at, input int snap_at, input int en_off_at,
                      output int n_wr, output int first_wr, output int last_wr,
                      output logic busy0, output logic busy2);
    int len;
    len      = wave.size();
    n_wr     = 0;
    first_wr = -1;
    last_wr  = -1;
    busy0    = 1'bx;
    busy2    = 1'bx;
    for (int i = 0; i < len + tail; i++) begin
      @(negedge clk);
      if (fifo_if.wr_en === 1'b1) begin
        n_wr++;
        if (first_wr < 0) first_wr = i;
        last_wr = i;
      end
      if (i == snap_at) busy0 = busy;
      if (i == snap_at + 2) busy2 = busy;
      if (i == rst_at) rst = 1'b1;
      else if (rst_at >= 0 && i == rst_at + 2) rst = 1'b0;
      if (i == en_off_at) decode_en = 1'b0;
      line = (i < len) ? wave[i] : 1'b1;
    end
    wave.delete();
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; decode_en = 1'b1; clr = 1'b0; line = 1'b1; fifo_if.fifo_full = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (fifo_if.rx_data !== 16'h0000 || fifo_if.wr_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: got rx_data=%h wr_en=%b want 0000/0", fifo_if.rx_data,
               fifo_if.wr_en);
    end
    checks++;
    if (frame_cnt !== 16'd0 || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_counters: got frame=%0d err=%0d want 0/0", frame_cnt, err_cnt);
    end
    checks++;
    if ({busy, parity_err, manch_err, overflow} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got busy/par/man/ovf=%b want 0000",
               {busy, parity_err, manch_err, overflow});
    end
  endtask

  task automatic test_valid_frame();
    int n, fw, lw;
    logic b0, b2;
    idle(16);
    add_frame(16'hA5C3, 12, 1'b0, -1);
    play(20, -1, -1, -1, n, fw, lw, b0, b2);
    checks++;
    if (n !== 1) begin errors++; $display("FAIL valid_wr_count: got %0d want 1", n); end
    checks++;
    if (fw !== 161) begin errors++; $display("FAIL valid_wr_time: got %0d want 161", fw); end
    checks++;
    if (fifo_if.rx_data !== 16'hA5C3) begin
      errors++; $display("FAIL valid_data: got %h want a5c3", fifo_if.rx_data);
    end
    checks++;
    if (frame_cnt !== 16'd1 || err_cnt !== 8'd0) begin
      errors++; $display("FAIL valid_counters: got frame=%0d err=%0d want 1/0", frame_cnt, err_cnt);
    end
    checks++;
    if ({parity_err, manch_err, overflow} !== 3'b000) begin
      errors++; $display("FAIL valid_flags: got %b want 000", {parity_err, manch_err, overflow});
    end
  endtask

  task automatic test_parity_error();
    int n, fw, lw;
    logic b0, b2;
    idle(16);
    add_frame(16'h0001, 12, 1'b1, -1);
    play(20, -1, -1, -1, n, fw, lw, b0, b2);
    checks++;
    if (n !== 0) begin errors++; $display("FAIL parity_no_write: got %0d writes want 0", n); end
    checks++;
    if (parity_err !== 1'b1 || err_cnt !== 8'd1) begin
      errors++; $display("FAIL parity_flag: got par=%b err=%0d want 1/1", parity_err, err_cnt);
    end
    pulse_clr();
    checks++;
    if (parity_err !== 1'b0 || err_cnt !== 8'd0 || frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL clr: got par=%b err=%0d frame=%0d want 0/0/0", parity_err, err_cnt, frame_cnt);
    end
    checks++;
    if (fifo_if.rx_data !== 16'hA5C3) begin
      errors++; $display("FAIL clr_keeps_data: got %h want a5c3", fifo_if.rx_data);
    end
  endtask

  task automatic test_manchester_error();
    int n, fw, lw;
    logic b0, b2;
    idle(16);
    add_frame(16'h0000, 12, 1'b0, 5);
    play(20, -1, -1, -1, n, fw, lw, b0, b2);
    checks++;
    if (n !== 0 || manch_err !== 1'b1 || err_cnt !== 8'd1 || parity_err !== 1'b0) begin
      errors++;
      $display("FAIL manch_detect: got wr=%0d man=%b err=%0d par=%b want 0/1/1/0", n, manch_err,
               err_cnt, parity_err);
    end
    idle(16);
    add_frame(16'h1234, 12, 1'b0, -1);
    play(20, -1, -1, -1, n, fw, lw, b0, b2);
    checks++;
    if (n !== 1 || fifo_if.rx_data !== 16'h1234 || frame_cnt !== 16'd1) begin
      errors++;
      $display("FAIL manch_recover: got wr=%0d data=%h frame=%0d want 1/1234/1", n,
               fifo_if.rx_data, frame_cnt);
    end
  endtask

  task automatic test_sync_tolerance();
    int n, fw, lw;
    logic b0, b2;
    idle(16);
    add_frame(16'h0000, 8, 1'b0, -1);
    play(20, -1, -1, -1, n, fw, lw, b0, b2);
    checks++;
    if (n !== 0 || frame_cnt !== 16'd1 || err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL sync_short: got wr=%0d frame=%0d err=%0d want 0/1/1", n, frame_cnt, err_cnt);
    end
    idle(16);
    add_frame(16'h0000, 15, 1'b0, -1);
    play(20, -1, -1, -1, n, fw, lw, b0, b2);
    checks++;
    if (n !== 0 || frame_cnt !== 16'd1 || err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL sync_long: got wr=%0d frame=%0d err=%0d want 0/1/1", n, frame_cnt, err_cnt);
    end
    idle(16);
    add_frame(16'h5A5A, 11, 1'b0, -1);
    play(20, -1, -1, -1, n, fw, lw, b0, b2);
    checks++;
    if (n !== 1 || fw !== 160 || fifo_if.rx_data !== 16'h5A5A || frame_cnt !== 16'd2) begin
      errors++;
      $display("FAIL sync_11: got wr=%0d at=%0d data=%h frame=%0d want 1/160/5a5a/2", n, fw,
               fifo_if.rx_data, frame_cnt);
    end
    idle(16);
    add_frame(16'h0F0F, 13, 1'b0, -1);
    play(20, -1, -1, -1, n, fw, lw, b0, b2);
    checks++;
    if (n !== 1 || fw !== 162 || fifo_if.rx_data !== 16'h0F0F || frame_cnt !== 16'd3) begin
      errors++;
      $display("FAIL sync_13: got wr=%0d at=%0d data=%h frame=%0d want 1/162/0f0f/3", n, fw,
               fifo_if.rx_data, frame_cnt);
    end
  endtask

  task automatic test_overflow_and_disable();
    int n, fw, lw;
    logic b0, b2;
    idle(16);
    fifo_if.fifo_full = 1'b1;
    add_frame(16'hBEEF, 12, 1'b0, -1);
    play(20, -1, -1, -1, n, fw, lw, b0, b2);
    fifo_if.fifo_full = 1'b0;
    checks++;
    if (n !== 0 || overflow !== 1'b1 || fifo_if.rx_data !== 16'h0F0F || frame_cnt !== 16'd3) begin
      errors++;
      $display("FAIL overflow: got wr=%0d ovf=%b data=%h frame=%0d want 0/1/0f0f/3", n, overflow,
               fifo_if.rx_data, frame_cnt);
    end
    idle(16);
    add_frame(16'hC0DE, 12, 1'b0, -1);
    play(20, -1, 90, 90, n, fw, lw, b0, b2);
    decode_en = 1'b1;
    checks++;
    if (b0 !== 1'b1 || b2 !== 1'b0) begin
      errors++; $display("FAIL disable_busy: got before=%b after=%b want 1/0", b0, b2);
    end
    checks++;
    if (n !== 0 || frame_cnt !== 16'd3) begin
      errors++; $display("FAIL disable_no_write: got wr=%0d frame=%0d want 0/3", n, frame_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int n, fw, lw;
    logic b0, b2;
    pulse_clr();
    idle(16);
    add_frame(16'hFFFF, 12, 1'b0, -1);
    add_idle(8);
    add_frame(16'h0000, 12, 1'b0, -1);
    play(20, -1, -1, -1, n, fw, lw, b0, b2);
    checks++;
    if (n !== 2 || fw !== 161 || lw !== 329) begin
      errors++; $display("FAIL b2b_writes: got n=%0d at=%0d,%0d want 2 at 161,329", n, fw, lw);
    end
    checks++;
    if (frame_cnt !== 16'd2 || fifo_if.rx_data !== 16'h0000 || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL b2b_state: got frame=%0d data=%h err=%0d want 2/0000/0", frame_cnt,
               fifo_if.rx_data, err_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n, fw, lw;
    logic b0, b2;
    idle(16);
    add_frame(16'hFFFF, 12, 1'b0, -1);
    add_idle(8);
    add_frame(16'h0000, 12, 1'b0, -1);
    play(20, 274, -1, -1, n, fw, lw, b0, b2);
    checks++;
    if (n !== 1 || fw !== 161) begin
      errors++; $display("FAIL rst_mid_writes: got n=%0d first=%0d want 1 at 161", n, fw);
    end
    checks++;
    if (frame_cnt !== 16'd0 || fifo_if.rx_data !== 16'h0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_state: got frame=%0d data=%h busy=%b want 0/0000/0", frame_cnt,
               fifo_if.rx_data, busy);
    end
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_parity_error();
    test_manchester_error();
    test_sync_tolerance();
    test_overflow_and_disable();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
